mips_exec_cmp_be: RTL and testbench

- Combinational datapath helper for the 5-stage MIPS pipeline, bundling three functions:
  - ALU: EX-stage arithmetic, logic and shifts.
  - Comparator: ID-stage branch resolution on forwarded rs/rt.
  - Byte-enable generator: MEM-stage store lane mask from address low bits.
- The ALU overflow output is also captured in one register, so later stages see overflow aligned to EX/MEM.

---
 rtl/mips_exec_pkg.sv | 33 +++
 rtl/mips_alu_core.sv | 64 ++++++
 rtl/mips_exec_cmp_be.sv | 74 +++++++
 tb/tb_mips_exec_cmp_be.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_exec_pkg.sv
// rtl/mips_exec_pkg.sv - shared op encodings for the MIPS EX/ID/MEM datapath helpers
package mips_exec_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_ADD  = 4'd12;
  localparam logic [3:0] ALU_SUB  = 4'd13;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LEZ = 3'd2;
  localparam logic [2:0] CMP_GTZ = 3'd3;
  localparam logic [2:0] CMP_LTZ = 3'd4;
  localparam logic [2:0] CMP_GEZ = 3'd5;

  localparam logic [1:0] BE_WORD = 2'd0;
  localparam logic [1:0] BE_HALF = 2'd1;
  localparam logic [1:0] BE_BYTE = 2'd2;
  localparam logic [1:0] BE_NONE = 2'd3;

endpackage

// File: rtl/mips_alu_core.sv
// rtl/mips_alu_core.sv - EX-stage ALU with signed overflow detect for ADD/SUB
module mips_alu_core
  import mips_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_overflow
);

  logic [DATA_W-1:0]        sum;
  logic [DATA_W-1:0]        diff;
  logic [4:0]               shamt;
  logic signed [DATA_W-1:0] sra_val;
  logic                     add_ovf;
  logic                     sub_ovf;

  // Shared adder/subtractor and overflow terms; the wrapped value is kept even on overflow
  always_comb begin
    sum     = alu_a + alu_b;
    diff    = alu_a - alu_b;
    shamt   = alu_a[4:0];
    sra_val = $signed(alu_b) >>> shamt;
    add_ovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (sum[DATA_W-1] != alu_a[DATA_W-1]);
    // Subtraction overflows when a and ~b share a sign, i.e. a and b differ in sign
    sub_ovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (diff[DATA_W-1] != alu_a[DATA_W-1]);
  end

  // Result mux; unused encodings produce zero
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      ALU_ADDU: alu_result = sum;
      ALU_SUBU: alu_result = diff;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_NOR:  alu_result = ~(alu_a | alu_b);
      ALU_SLL:  alu_result = alu_b << shamt;
      ALU_SRL:  alu_result = alu_b >> shamt;
      ALU_SRA:  alu_result = sra_val;
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
      ALU_LUI:  alu_result = {alu_b[15:0], 16'h0000};
      ALU_ADD: begin
        alu_result   = sum;
        alu_overflow = add_ovf;
      end
      ALU_SUB: begin
        alu_result   = diff;
        alu_overflow = sub_ovf;
      end
      default: begin
        alu_result   = '0;
        alu_overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_exec_cmp_be.sv
// rtl/mips_exec_cmp_be.sv - ALU, branch comparator, store byte enables and registered overflow
module mips_exec_cmp_be
  import mips_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_overflow,
  output logic              ovf_q,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  input  logic [2:0]        cmp_op,
  output logic              cmp_result,
  input  logic [1:0]        be_addr,
  input  logic [1:0]        be_op,
  output logic [3:0]        be_out
);

  logic a_neg;
  logic a_zero;

  mips_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow)
  );

  // Branch condition on forwarded rs/rt; zero-compares look at cmp_a only
  always_comb begin
    a_neg      = cmp_a[DATA_W-1];
    a_zero     = (cmp_a == '0);
    cmp_result = 1'b0;
    case (cmp_op)
      CMP_EQ:  cmp_result = (cmp_a == cmp_b);
      CMP_NE:  cmp_result = (cmp_a != cmp_b);
      CMP_LEZ: cmp_result = a_neg | a_zero;
      CMP_GTZ: cmp_result = ~a_neg & ~a_zero;
      CMP_LTZ: cmp_result = a_neg;
      CMP_GEZ: cmp_result = ~a_neg;
      default: cmp_result = 1'b0;
    endcase
  end

  // Store lane mask; halfword ignores addr[0], misalignment is handled elsewhere
  always_comb begin
    be_out = 4'b0000;
    case (be_op)
      BE_WORD: be_out = 4'b1111;
      BE_HALF: be_out = be_addr[1] ? 4'b1100 : 4'b0011;
      BE_BYTE: be_out = 4'b0001 << be_addr;
      BE_NONE: be_out = 4'b0000;
      default: be_out = 4'b0000;
    endcase
  end

  // Overflow aligned to EX/MEM; cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= alu_overflow;
    end
  end

endmodule

// File: tb/tb_mips_exec_cmp_be.sv
// tb/tb_mips_exec_cmp_be.sv - directed self-checking bench for mips_exec_cmp_be
module tb_mips_exec_cmp_be;

  logic        clk;
  logic        reset;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        ovf_q;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [2:0]  cmp_op;
  logic        cmp_result;
  logic [1:0]  be_addr;
  logic [1:0]  be_op;
  logic [3:0]  be_out;

  int total;
  int bad;

  mips_exec_cmp_be #(
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .ovf_q        (ovf_q),
    .cmp_a        (cmp_a),
    .cmp_b        (cmp_b),
    .cmp_op       (cmp_op),
    .cmp_result   (cmp_result),
    .be_addr      (be_addr),
    .be_op        (be_op),
    .be_out       (be_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    alu_a  = a;
    alu_b  = b;
    alu_op = op;
    #1;
  endtask

  task automatic cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    cmp_a  = a;
    cmp_b  = b;
    cmp_op = op;
    #1;
  endtask

  task automatic be(input logic [1:0] addr, input logic [1:0] op);
    be_addr = addr;
    be_op   = op;
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 4'd0;
    cmp_a   = '0;
    cmp_b   = '0;
    cmp_op  = 3'd0;
    be_addr = 2'd0;
    be_op   = 2'd0;

    @(posedge clk);
    #1;
    chk("reset_ovf_q", {31'b0, ovf_q}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADD overflow and registered copy
    alu(32'h7FFFFFFF, 32'h1, 4'd12);
    chk("add_res", alu_result, 32'h80000000);
    chk("add_ovf", {31'b0, alu_overflow}, 32'd1);
    @(posedge clk);
    #1;
    chk("add_ovf_q", {31'b0, ovf_q}, 32'd1);
    @(negedge clk);
    alu(32'h7FFFFFFF, 32'h1, 4'd0);
    chk("addu_res", alu_result, 32'h80000000);
    chk("addu_ovf", {31'b0, alu_overflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("addu_ovf_q", {31'b0, ovf_q}, 32'd0);
    @(negedge clk);

    // Logic ops and SUBU
    alu(32'h00000005, 32'h00000007, 4'd1);
    chk("subu", alu_result, 32'hFFFFFFFE);
    alu(32'hF0F000FF, 32'h0FF00F0F, 4'd2);
    chk("and", alu_result, 32'h00F0000F);
    alu(32'hF0F000FF, 32'h0FF00F0F, 4'd3);
    chk("or", alu_result, 32'hFFF00FFF);
    alu(32'hF0F000FF, 32'h0FF00F0F, 4'd4);
    chk("xor", alu_result, 32'hFF000FF0);
    alu(32'hF0F000FF, 32'h0FF00F0F, 4'd5);
    chk("nor", alu_result, 32'h000FF000);

    // Shifts, including upper amount bits ignored and zero shift
    alu(32'h4, 32'h80000010, 4'd6);
    chk("sll", alu_result, 32'h00000100);
    alu(32'h4, 32'h80000010, 4'd7);
    chk("srl", alu_result, 32'h08000001);
    alu(32'h4, 32'h80000010, 4'd8);
    chk("sra", alu_result, 32'hF8000001);
    alu(32'h24, 32'h80000010, 4'd6);
    chk("sll_hi", alu_result, 32'h00000100);
    alu(32'h24, 32'h80000010, 4'd7);
    chk("srl_hi", alu_result, 32'h08000001);
    alu(32'h24, 32'h80000010, 4'd8);
    chk("sra_hi", alu_result, 32'hF8000001);
    alu(32'h20, 32'h80000010, 4'd8);
    chk("sra_zero", alu_result, 32'h80000010);

    // Set-less-than, LUI, unused op
    alu(32'hFFFFFFFF, 32'h1, 4'd9);
    chk("slt", alu_result, 32'h1);
    alu(32'hFFFFFFFF, 32'h1, 4'd10);
    chk("sltu", alu_result, 32'h0);
    alu(32'h0, 32'h00001234, 4'd11);
    chk("lui", alu_result, 32'h12340000);
    alu(32'h7FFFFFFF, 32'h1, 4'd14);
    chk("op14_res", alu_result, 32'h0);
    chk("op14_ovf", {31'b0, alu_overflow}, 32'd0);

    // Comparator
    cmp(32'h5, 32'h5, 3'd0);
    chk("cmp_eq", {31'b0, cmp_result}, 32'd1);
    cmp(32'h5, 32'h5, 3'd1);
    chk("cmp_ne", {31'b0, cmp_result}, 32'd0);
    cmp(32'h5, 32'h6, 3'd0);
    chk("cmp_eq_diff", {31'b0, cmp_result}, 32'd0);
    cmp(32'h0, 32'hFFFFFFFF, 3'd2);
    chk("lez_0", {31'b0, cmp_result}, 32'd1);
    cmp(32'h0, 32'hFFFFFFFF, 3'd3);
    chk("gtz_0", {31'b0, cmp_result}, 32'd0);
    cmp(32'h0, 32'hFFFFFFFF, 3'd5);
    chk("gez_0", {31'b0, cmp_result}, 32'd1);
    cmp(32'h0, 32'hFFFFFFFF, 3'd4);
    chk("ltz_0", {31'b0, cmp_result}, 32'd0);
    cmp(32'h80000000, 32'h0, 3'd4);
    chk("ltz_neg", {31'b0, cmp_result}, 32'd1);
    cmp(32'h80000000, 32'h0, 3'd2);
    chk("lez_neg", {31'b0, cmp_result}, 32'd1);
    cmp(32'h5, 32'h0, 3'd3);
    chk("gtz_pos", {31'b0, cmp_result}, 32'd1);
    cmp(32'h5, 32'h5, 3'd6);
    chk("cmp_op6", {31'b0, cmp_result}, 32'd0);

    // Byte enables
    be(2'd0, 2'd2);
    chk("be_b0", {28'b0, be_out}, 32'h1);
    be(2'd1, 2'd2);
    chk("be_b1", {28'b0, be_out}, 32'h2);
    be(2'd2, 2'd2);
    chk("be_b2", {28'b0, be_out}, 32'h4);
    be(2'd3, 2'd2);
    chk("be_b3", {28'b0, be_out}, 32'h8);
    be(2'd2, 2'd1);
    chk("be_h2", {28'b0, be_out}, 32'hC);
    be(2'd1, 2'd1);
    chk("be_h1", {28'b0, be_out}, 32'h3);
    be(2'd3, 2'd0);
    chk("be_w3", {28'b0, be_out}, 32'hF);
    be(2'd1, 2'd3);
    chk("be_none", {28'b0, be_out}, 32'h0);

    // Asynchronous reset of ovf_q while combinational overflow persists
    @(negedge clk);
    alu(32'h80000000, 32'h1, 4'd13);
    chk("sub_res", alu_result, 32'h7FFFFFFF);
    chk("sub_ovf", {31'b0, alu_overflow}, 32'd1);
    @(posedge clk);
    #1;
    chk("sub_ovf_q", {31'b0, ovf_q}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ovf_q", {31'b0, ovf_q}, 32'd0);
    chk("rst_alu_ovf", {31'b0, alu_overflow}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ovf_q_hold", {31'b0, ovf_q}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ovf_q", {31'b0, ovf_q}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
